// File: rtl/nic_pkg.sv
// nic_pkg: register map, status bit layout and polarity-bit helper for the NIC.
package nic_pkg;
  localparam logic [1:0] INPUT_BUFFER  = 2'd0;
  localparam logic [1:0] INPUT_STATUS  = 2'd1;
  localparam logic [1:0] OUTPUT_BUFFER = 2'd2;
  localparam logic [1:0] OUTPUT_STATUS = 2'd3;
  localparam int ST_VALID   = 0;
  localparam int ST_OVF     = 1;
  localparam int ST_FULL    = 2;
  localparam int ST_CNT_LSB = 8;
  function automatic int pol_bit(input int w);
    return w - 1;
  endfunction
endpackage

// File: rtl/nic_sync_fifo.sv
// nic_sync_fifo: power-of-two synchronous FIFO; a push while full is accepted only alongside a pop.
module nic_sync_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] din_i,
  output logic [WIDTH-1:0] head_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CNT_W-1:0] count_o
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic do_push, do_pop;
  assign empty_o = cnt_q == '0;
  assign full_o  = cnt_q == CNT_W'(DEPTH);
  assign do_pop  = pop_i & !empty_o;
  assign do_push = push_i & (!full_o | do_pop);
  assign head_o  = mem_q[rd_q];
  assign count_o = cnt_q;
  always_comb begin
    wr_d  = do_push ? wr_q + 1'b1 : wr_q;
    rd_d  = do_pop ? rd_q + 1'b1 : rd_q;
    cnt_d = cnt_q + CNT_W'(do_push) - CNT_W'(do_pop);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end
  // storage needs no reset: head is only observed while the FIFO is non-empty
  always_ff @(posedge clk)
    if (do_push) mem_q[wr_q] <= din_i;
endmodule

// File: rtl/nic_fifo_if.sv
// nic_fifo_if: processor-register to ring-router NIC with input/output FIFOs and sticky overflow status.
module nic_fifo_if
  import nic_pkg::*;
#(
  parameter int DATA_W    = 64,
  parameter int IN_DEPTH  = 4,
  parameter int OUT_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        addr,
  input  logic [DATA_W-1:0] d_in,
  input  logic              nicEn,
  input  logic              nicWrEn,
  output logic [DATA_W-1:0] d_out,
  output logic              net_so,
  input  logic              net_ro,
  output logic [DATA_W-1:0] net_do,
  input  logic              net_polarity,
  input  logic              net_si,
  output logic              net_ri,
  input  logic [DATA_W-1:0] net_di
);
  localparam int CNT_W = $clog2((IN_DEPTH > OUT_DEPTH ? IN_DEPTH : OUT_DEPTH) + 1);
  localparam int PB = pol_bit(DATA_W);
  logic [DATA_W-1:0] in_head, out_head, in_st, out_st, d_out_q, d_out_d;
  logic [CNT_W-1:0] in_cnt, out_cnt;
  logic in_full, in_empty, out_full, out_empty;
  logic wr_en, rd_en, out_push, rd_in;
  logic in_ovf_q, in_ovf_d, out_ovf_q, out_ovf_d;
  assign wr_en    = nicEn & nicWrEn;
  assign rd_en    = nicEn & !nicWrEn;
  assign out_push = wr_en & (addr == OUTPUT_BUFFER);
  assign rd_in    = rd_en & (addr == INPUT_BUFFER) & !in_empty;
  assign net_so   = !out_empty & net_ro & (out_head[PB] == ~net_polarity);
  assign net_do   = out_empty ? '0 : out_head;
  assign net_ri   = !in_full | rd_in;
  assign d_out    = d_out_q;
  assign in_st  = (DATA_W'(in_cnt) << ST_CNT_LSB) | (DATA_W'(in_ovf_q) << ST_OVF)
                | (DATA_W'(!in_empty) << ST_VALID);
  assign out_st = (DATA_W'(out_cnt) << ST_CNT_LSB) | (DATA_W'(out_full) << ST_FULL)
                | (DATA_W'(out_ovf_q) << ST_OVF) | (DATA_W'(!out_empty) << ST_VALID);
  // overflow set takes priority over a same-cycle clear
  always_comb begin
    in_ovf_d  = (net_si & in_full & !rd_in) | (in_ovf_q & !(wr_en & (addr == INPUT_STATUS)));
    out_ovf_d = (out_push & out_full & !net_so) | (out_ovf_q & !(wr_en & (addr == OUTPUT_STATUS)));
    d_out_d   = !nicEn ? '0 :
                nicWrEn ? d_out_q :
                addr == INPUT_BUFFER ? (in_empty ? '0 : in_head) :
                addr == INPUT_STATUS ? in_st :
                addr == OUTPUT_STATUS ? out_st : d_out_q;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      in_ovf_q  <= 1'b0;
      out_ovf_q <= 1'b0;
      d_out_q   <= '0;
    end else begin
      in_ovf_q  <= in_ovf_d;
      out_ovf_q <= out_ovf_d;
      d_out_q   <= d_out_d;
    end
  end
  nic_sync_fifo #(.WIDTH(DATA_W), .DEPTH(IN_DEPTH), .CNT_W(CNT_W)) u_in_fifo (
    .clk(clk), .reset(reset), .push_i(net_si), .pop_i(rd_in), .din_i(net_di),
    .head_o(in_head), .full_o(in_full), .empty_o(in_empty), .count_o(in_cnt)
  );
  nic_sync_fifo #(.WIDTH(DATA_W), .DEPTH(OUT_DEPTH), .CNT_W(CNT_W)) u_out_fifo (
    .clk(clk), .reset(reset), .push_i(out_push), .pop_i(net_so), .din_i(d_in),
    .head_o(out_head), .full_o(out_full), .empty_o(out_empty), .count_o(out_cnt)
  );
endmodule

// File: tb/tb_nic_fifo_if.sv
// tb_nic_fifo_if: directed scenarios plus randomized traffic against a queue-based NIC model.
module tb_nic_fifo_if;
  localparam int W = 64, ID = 4, OD = 4;
  logic clk = 0, reset = 1;
  logic [1:0] addr = 0;
  logic [W-1:0] d_in = 0, net_di = 0;
  logic nicEn = 0, nicWrEn = 0, net_ro = 0, net_polarity = 0, net_si = 0;
  logic [W-1:0] d_out, net_do;
  logic net_so, net_ri;
  int checks = 0, errors = 0;
  logic [W-1:0] inq[$], outq[$];
  bit m_iovf, m_oovf;
  logic [W-1:0] m_dout;
  bit e_so, e_ri, s_so, s_ri;
  logic [W-1:0] e_do, s_do;

  nic_fifo_if #(.DATA_W(W), .IN_DEPTH(ID), .OUT_DEPTH(OD)) dut (
    .clk(clk), .reset(reset), .addr(addr), .d_in(d_in), .nicEn(nicEn), .nicWrEn(nicWrEn),
    .d_out(d_out), .net_so(net_so), .net_ro(net_ro), .net_do(net_do),
    .net_polarity(net_polarity), .net_si(net_si), .net_ri(net_ri), .net_di(net_di)
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] in_stat();
    return (W'(inq.size()) << 8) | (W'(m_iovf) << 1) | W'(inq.size() != 0);
  endfunction
  function automatic logic [W-1:0] out_stat();
    return (W'(outq.size()) << 8) | (W'(outq.size() == OD) << 2) | (W'(m_oovf) << 1) | W'(outq.size() != 0);
  endfunction

  task automatic tick();
    bit so, rdin, ifull, ofull, iset, oset;
    logic [W-1:0] nd;
    #1;
    s_so = net_so; s_ri = net_ri; s_do = net_do;
    so = outq.size() != 0 && net_ro && (outq[0][W-1] == !net_polarity);
    rdin = nicEn && !nicWrEn && addr == 0 && inq.size() != 0;
    e_so = so;
    e_ri = inq.size() < ID || rdin;
    e_do = outq.size() != 0 ? outq[0] : '0;
    nd = m_dout;
    if (!nicEn) nd = '0;
    else if (!nicWrEn)
      case (addr)
        2'd0: nd = rdin ? inq[0] : '0;
        2'd1: nd = in_stat();
        2'd3: nd = out_stat();
        default: ;
      endcase
    ifull = inq.size() == ID;
    ofull = outq.size() == OD;
    iset = 0; oset = 0;
    @(posedge clk);
    if (reset) begin
      inq.delete(); outq.delete(); m_iovf = 0; m_oovf = 0; m_dout = '0;
    end else begin
      m_dout = nd;
      if (so) void'(outq.pop_front());
      if (nicEn && nicWrEn && addr == 2) begin
        if (!ofull || so) outq.push_back(d_in); else oset = 1;
      end
      if (rdin) void'(inq.pop_front());
      if (net_si) begin
        if (!ifull || rdin) inq.push_back(net_di); else iset = 1;
      end
      m_oovf = oset || (m_oovf && !(nicEn && nicWrEn && addr == 3));
      m_iovf = iset || (m_iovf && !(nicEn && nicWrEn && addr == 1));
    end
    #1;
  endtask

  task automatic set(input bit en, input bit wr, input logic [1:0] a, input logic [W-1:0] d);
    nicEn = en; nicWrEn = wr; addr = a; d_in = d;
  endtask

  task automatic do_reset();
    set(0, 0, 0, 0); net_si = 0; net_ro = 0; reset = 1;
    tick();
    reset = 0;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    checks++; if (d_out !== '0) begin errors++; $display("FAIL reset_dout got %h exp 0", d_out); end
    checks++; if (net_so !== 1'b0) begin errors++; $display("FAIL reset_so got %b exp 0", net_so); end
    checks++; if (net_do !== '0) begin errors++; $display("FAIL reset_do got %h exp 0", net_do); end
    checks++; if (net_ri !== 1'b1) begin errors++; $display("FAIL reset_ri got %b exp 1", net_ri); end
  endtask

  task automatic test_polarity();
    logic [W-1:0] w = 64'h8000_0000_0000_0001;
    do_reset();
    net_ro = 1; net_polarity = 1;
    set(1, 1, 2, w); tick(); set(0, 0, 0, 0);
    #1;
    checks++; if (net_so !== 1'b0) begin errors++; $display("FAIL pol_block got %b exp 0", net_so); end
    checks++; if (net_do !== w) begin errors++; $display("FAIL pol_head got %h exp %h", net_do, w); end
    tick();
    net_polarity = 0;
    #1;
    checks++; if (net_so !== 1'b1) begin errors++; $display("FAIL pol_send got %b exp 1", net_so); end
    checks++; if (net_do !== w) begin errors++; $display("FAIL pol_do got %h exp %h", net_do, w); end
    tick();
    checks++; if (net_so !== 1'b0) begin errors++; $display("FAIL pol_once got %b exp 0", net_so); end
    set(1, 0, 3, 0); tick(); set(0, 0, 0, 0);
    checks++; if (d_out[0] !== 1'b0) begin errors++; $display("FAIL pol_status got %h exp lsb 0", d_out); end
  endtask

  task automatic test_out_overflow();
    logic [W-1:0] w[5];
    do_reset();
    net_polarity = 1;
    for (int i = 0; i < 5; i++) begin
      w[i] = {1'b0, 31'($urandom), 32'($urandom)};
      set(1, 1, 2, w[i]); tick();
    end
    set(1, 0, 3, 0); tick();
    checks++; if (d_out !== 64'h407) begin errors++; $display("FAIL ovf_status got %h exp 407", d_out); end
    set(1, 1, 3, 0); tick();
    set(1, 0, 3, 0); tick(); set(0, 0, 0, 0);
    checks++; if (d_out !== 64'h405) begin errors++; $display("FAIL ovf_clear got %h exp 405", d_out); end
    net_ro = 1;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++; if (net_so !== 1'b1 || net_do !== w[i])
        begin errors++; $display("FAIL drain%0d got so=%b do=%h exp so=1 do=%h", i, net_so, net_do, w[i]); end
      tick();
    end
    checks++; if (net_so !== 1'b0) begin errors++; $display("FAIL drain_end got %b exp 0", net_so); end
  endtask

  task automatic test_input();
    logic [W-1:0] p[5];
    do_reset();
    for (int i = 0; i < 5; i++) p[i] = {32'($urandom), 32'($urandom)};
    for (int i = 0; i < 4; i++) begin
      net_si = 1; net_di = p[i];
      #1;
      checks++; if (net_ri !== 1'b1) begin errors++; $display("FAIL in_ri%0d got %b exp 1", i, net_ri); end
      tick();
    end
    net_si = 0;
    #1;
    checks++; if (net_ri !== 1'b0) begin errors++; $display("FAIL in_full_ri got %b exp 0", net_ri); end
    set(1, 0, 0, 0); net_si = 1; net_di = p[4];
    #1;
    checks++; if (net_ri !== 1'b1) begin errors++; $display("FAIL in_rd_ri got %b exp 1", net_ri); end
    tick(); net_si = 0;
    checks++; if (d_out !== p[0]) begin errors++; $display("FAIL in_rd got %h exp %h", d_out, p[0]); end
    set(1, 0, 1, 0); tick();
    checks++; if (d_out !== 64'h401) begin errors++; $display("FAIL in_cnt got %h exp 401", d_out); end
    set(1, 0, 0, 0); tick(); set(0, 0, 0, 0);
    checks++; if (d_out !== p[1]) begin errors++; $display("FAIL in_rd2 got %h exp %h", d_out, p[1]); end
  endtask

  task automatic test_empty_read();
    logic [W-1:0] p = {32'($urandom), 32'($urandom)};
    do_reset();
    set(1, 0, 0, 0); tick();
    checks++; if (d_out !== '0) begin errors++; $display("FAIL empty_rd got %h exp 0", d_out); end
    set(1, 0, 1, 0); tick();
    checks++; if (d_out !== '0) begin errors++; $display("FAIL empty_cnt got %h exp 0", d_out); end
    set(1, 0, 0, 0); net_si = 1; net_di = p; tick(); net_si = 0;
    checks++; if (d_out !== '0) begin errors++; $display("FAIL empty_same got %h exp 0", d_out); end
    set(1, 0, 1, 0); tick();
    checks++; if (d_out !== 64'h101) begin errors++; $display("FAIL empty_cnt1 got %h exp 101", d_out); end
    set(1, 0, 0, 0); tick(); set(0, 0, 0, 0);
    checks++; if (d_out !== p) begin errors++; $display("FAIL empty_pkt got %h exp %h", d_out, p); end
  endtask

  task automatic test_violation();
    logic [W-1:0] first = 0;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      net_si = 1; net_di = {32'($urandom), 32'($urandom)};
      if (i == 0) first = net_di;
      tick();
    end
    net_si = 0;
    set(1, 0, 1, 0); tick();
    checks++; if (d_out !== 64'h403) begin errors++; $display("FAIL viol_set got %h exp 403", d_out); end
    set(1, 1, 1, 0); net_si = 1; tick(); net_si = 0;
    set(1, 0, 1, 0); tick();
    checks++; if (d_out !== 64'h403) begin errors++; $display("FAIL viol_setwins got %h exp 403", d_out); end
    set(1, 1, 1, 0); tick();
    set(1, 0, 1, 0); tick();
    checks++; if (d_out !== 64'h401) begin errors++; $display("FAIL viol_clear got %h exp 401", d_out); end
    set(1, 0, 0, 0); tick(); set(0, 0, 0, 0);
    checks++; if (d_out !== first) begin errors++; $display("FAIL viol_head got %h exp %h", d_out, first); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      set(1, 1, 2, {1'b0, 31'($urandom), 32'($urandom)});
      net_si = 1; net_di = {32'($urandom), 32'($urandom)};
      tick();
    end
    set(1, 0, 1, 0); net_si = 0; tick();
    set(0, 0, 0, 0); net_ro = 1; net_polarity = 1;
    #1;
    checks++; if (net_so !== 1'b1) begin errors++; $display("FAIL mid_pre_so got %b exp 1", net_so); end
    reset = 1; tick(); reset = 0;
    #1;
    checks++; if (net_so !== 1'b0 || net_do !== '0 || d_out !== '0)
      begin errors++; $display("FAIL mid_outs got so=%b do=%h dout=%h exp 0", net_so, net_do, d_out); end
    for (int a = 0; a < 4; a++) begin
      if (a == 2) continue;
      set(1, 0, 2'(a), 0); tick();
      checks++; if (d_out !== '0) begin errors++; $display("FAIL mid_rd%0d got %h exp 0", a, d_out); end
    end
    set(0, 0, 0, 0);
  endtask

  task automatic test_random();
    do_reset();
    for (int n = 0; n < 800; n++) begin
      reset = ($urandom_range(0, 99) == 0);
      set($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, 2'($urandom), {32'($urandom), 32'($urandom)});
      net_si = $urandom_range(0, 1) == 1;
      net_di = {32'($urandom), 32'($urandom)};
      net_ro = $urandom_range(0, 2) != 0;
      if ($urandom_range(0, 7) == 0) net_polarity = !net_polarity;
      tick();
      checks++; if (s_so !== e_so || s_ri !== e_ri || s_do !== e_do)
        begin errors++; $display("FAIL rnd_net%0d got so=%b ri=%b do=%h exp so=%b ri=%b do=%h", n, s_so, s_ri, s_do, e_so, e_ri, e_do); end
      checks++; if (d_out !== m_dout)
        begin errors++; $display("FAIL rnd_dout%0d got %h exp %h", n, d_out, m_dout); end
    end
    reset = 0;
  endtask

  initial begin
    test_reset();
    test_polarity();
    test_out_overflow();
    test_input();
    test_empty_read();
    test_violation();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/nic_fifo_if.md
Name: nic_fifo_if

Overview:
- Parametrised network interface controller between a processor register port and one ring-router port.
- Replaces the single-entry input/output buffers with independent input and output FIFOs of configurable depth and data width.
- Adds occupancy and sticky overflow reporting through the status registers.
- Keeps the polarity-gated send rule toward the router and the four-address register map.

Parameters:
- DATA_W, 64, packet and processor data width; the packet MSB is the polarity (VC) bit.
- IN_DEPTH, 4, input FIFO entries; power of two, ≥2.
- OUT_DEPTH, 4, output FIFO entries; power of two, ≥2.
- CNT_W, $clog2(max(IN_DEPTH,OUT_DEPTH)+1), derived occupancy width; not overridable.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- addr  in  2  register select: 0 INPUT_BUFFER, 1 INPUT_STATUS, 2 OUTPUT_BUFFER, 3 OUTPUT_STATUS
- d_in  in  DATA_W  processor write data
- nicEn  in  1  processor access enable
- nicWrEn  in  1  1 = write, 0 = read (qualified by nicEn)
- d_out  out  DATA_W  registered processor read data
- net_so  out  1  send strobe to router
- net_ro  in  1  router ready to accept
- net_do  out  DATA_W  output FIFO head packet
- net_polarity  in  1  current ring polarity
- net_si  in  1  router delivers packet
- net_ri  out  1  NIC can accept a packet
- net_di  in  DATA_W  incoming packet

Behaviour:
- Reset (clk edge with reset=1): both FIFOs empty, counts 0, in_ovf=out_ovf=0, d_out=0. Reset mid-transfer discards all queued packets. net_so and net_do are 0 after reset.
- Output path:
  - push = nicEn & nicWrEn & addr==2.
  - Accepted if out FIFO not full, or full with a pop in the same cycle.
  - A push while full with no pop drops the word and sets out_ovf.
  - net_so = !out_empty & net_ro & (head MSB == ~net_polarity). Combinational; pops the head on the same edge.
  - net_do = head when non-empty, else 0.
  - A head with the wrong polarity blocks the queue (no reordering).
- Input path:
  - rd_in = nicEn & !nicWrEn & addr==0 & !in_empty.
  - net_ri = !in_full | rd_in.
  - net_si pushes net_di. If net_si arrives while full and !rd_in (protocol violation), the packet is dropped and in_ovf is set.
  - Push and pop in the same cycle: count unchanged; when the FIFO is empty, the pushed entry is stored and the read returns empty-read data.
- d_out (1-cycle read latency, registered):
  - reset or !nicEn → 0.
  - Write cycle → hold.
  - Read addr 0: head if non-empty (and pop); 0 if empty (no state change).
  - Read addr 1: LSB = !in_empty; bit 1 = in_ovf; bits [8+CNT_W-1:8] (LSB-relative) = in count; others 0.
  - Read addr 2: hold.
  - Read addr 3: LSB = !out_empty (entry pending); bit 1 = out_ovf; bit 2 = out_full; bits [8+CNT_W-1:8] = out count.
- Overflow clear:
  - Write to addr 1 clears in_ovf; write to addr 3 clears out_ovf. Data is ignored.
  - A set and a clear in the same cycle: set wins.
  - Write to addr 0 is ignored.
- Count wrap: pointers wrap modulo depth; count saturates by construction at depth (never exceeds it).

Decomposition:
- Package nic_pkg:
  - address constants (INPUT_BUFFER, INPUT_STATUS, OUTPUT_BUFFER, OUTPUT_STATUS);
  - status bit positions (ST_VALID=0, ST_OVF=1, ST_FULL=2, ST_CNT_LSB=8);
  - polarity-bit index.
- Sub-module nic_sync_fifo (parameters WIDTH, DEPTH), instantiated twice:
  - ports: push, pop, din, head, full, empty, count.
  - simultaneous push/pop allowed when full.

Test Plan:
- Polarity gating: OUT_DEPTH=4; write 0x8000_0000_0000_0001 (MSB=1) with net_polarity=1, net_ro=1 → net_so stays 0. Flip net_polarity to 0 → net_so=1 for one cycle, net_do=that word, OUTPUT_STATUS LSB reads 0 afterwards.
- Output fill/overflow: net_ro=0; write 5 words → status reads count=4, full=1, ovf=1, and the 5th word is absent. Write addr 3 → ovf=0. Drain with net_ro=1 → 4 words appear in order.
- Input FIFO: push 4 packets via net_si → net_ri=0. Read addr 0 → d_out=first packet one cycle later, and net_ri=1 during the read cycle. Simultaneous net_si and read keeps count=4.
- Empty read: read addr 0 with input empty → d_out=0, count stays 0. Same-cycle net_si → count=1 and the next read returns that packet.
- Protocol violation: input full, net_si without read → packet dropped, INPUT_STATUS bit 1=1; write addr 1 → cleared.
- Reset mid-operation: 3 queued each way, assert reset one cycle → net_so=0, net_do=0, all status reads return 0, d_out=0.
